elevator_motion_ctrl: RTL and testbench



---
 rtl/elevator_motion_ctrl.sv | 162 ++++++++++++++++
 tb/tb_elevator_motion_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_motion_ctrl.sv
// Sequential elevator controller: latches floor requests, times per-floor travel and
// door dwell, picks direction with a SCAN policy and drives registered motor/door outputs.
module elevator_motion_ctrl #(
    parameter int NUM_FLOORS    = 5,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  estop,
    output logic [FLOOR_W-1:0]    floor,
    output logic [NUM_FLOORS-1:0] floor_onehot,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  up,
    output logic                  down,
    output logic                  stop,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MOVE_UP   = 2'd1;
    localparam logic [1:0] MOVE_DOWN = 2'd2;
    localparam logic [1:0] DOOR      = 2'd3;

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0]         TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]         DOOR_LAST   = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]    TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] ONE         = NUM_FLOORS'(1);

    logic [1:0]            state, state_n;
    logic [FLOOR_W-1:0]    floor_n;
    logic                  dir_up_n;
    logic [TW-1:0]         travel_cnt, travel_n;
    logic [DW-1:0]         door_cnt, door_n;
    logic                  estop_q;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [NUM_FLOORS-1:0] req_seen;
    logic [NUM_FLOORS-1:0] cur_mask, up_mask, down_mask;
    logic                  any_above, any_below;

    assign req_seen  = pending | req;
    assign cur_mask  = ONE << floor;
    assign up_mask   = ONE << (floor + FLOOR_W'(1));
    assign down_mask = ONE << (floor - FLOOR_W'(1));

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i > int'(floor))) any_above = 1'b1;
            if (pending[i] && (i < int'(floor))) any_below = 1'b1;
        end
    end

    // While estop_q is high every default holds, so only the request latch moves.
    always_comb begin
        state_n    = state;
        floor_n    = floor;
        dir_up_n   = dir_up;
        travel_n   = travel_cnt;
        door_n     = door_cnt;
        clear_mask = '0;
        if (!estop_q) begin
            case (state)
                IDLE: begin
                    if (|(pending & cur_mask)) begin
                        state_n    = DOOR;
                        door_n     = '0;
                        clear_mask = cur_mask;
                    end else if (any_above && (dir_up || !any_below)) begin
                        state_n  = MOVE_UP;
                        dir_up_n = 1'b1;
                        travel_n = '0;
                    end else if (any_below) begin
                        state_n  = MOVE_DOWN;
                        dir_up_n = 1'b0;
                        travel_n = '0;
                    end
                end
                MOVE_UP: begin
                    if (floor == TOP_FLOOR) begin
                        state_n  = IDLE;
                        travel_n = '0;
                    end else if (travel_cnt == TRAVEL_LAST) begin
                        floor_n  = floor + FLOOR_W'(1);
                        travel_n = '0;
                        if (|(req_seen & up_mask)) begin
                            state_n    = DOOR;
                            door_n     = '0;
                            clear_mask = up_mask;
                        end
                    end else begin
                        travel_n = travel_cnt + TW'(1);
                    end
                end
                MOVE_DOWN: begin
                    if (floor == '0) begin
                        state_n  = IDLE;
                        travel_n = '0;
                    end else if (travel_cnt == TRAVEL_LAST) begin
                        floor_n  = floor - FLOOR_W'(1);
                        travel_n = '0;
                        if (|(req_seen & down_mask)) begin
                            state_n    = DOOR;
                            door_n     = '0;
                            clear_mask = down_mask;
                        end
                    end else begin
                        travel_n = travel_cnt + TW'(1);
                    end
                end
                DOOR: begin
                    // A call to the floor we are standing at reopens the door instead of latching.
                    if (|(req & cur_mask)) begin
                        door_n     = '0;
                        clear_mask = cur_mask;
                    end else if (door_cnt == DOOR_LAST) begin
                        state_n = IDLE;
                        door_n  = '0;
                    end else begin
                        door_n = door_cnt + DW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            floor      <= '0;
            dir_up     <= 1'b1;
            pending    <= '0;
            travel_cnt <= '0;
            door_cnt   <= '0;
            estop_q    <= 1'b0;
        end else begin
            state      <= state_n;
            floor      <= floor_n;
            dir_up     <= dir_up_n;
            pending    <= req_seen & ~clear_mask;
            travel_cnt <= travel_n;
            door_cnt   <= door_n;
            estop_q    <= estop;
        end
    end

    assign up           = (state == MOVE_UP) & ~estop_q;
    assign down         = (state == MOVE_DOWN) & ~estop_q;
    assign stop         = ~(up | down);
    assign door_open    = (state == DOOR);
    assign floor_onehot = cur_mask;
    assign state_dbg    = state;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed bench for elevator_motion_ctrl with default parameters (5 floors, travel 4, door 3).
module tb_elevator_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] req;
    logic       estop;
    logic [2:0] floor;
    logic [4:0] floor_onehot;
    logic [4:0] pending;
    logic       up, down, stop, door_open, dir_up;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    elevator_motion_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .estop        (estop),
        .floor        (floor),
        .floor_onehot (floor_onehot),
        .pending      (pending),
        .up           (up),
        .down         (down),
        .stop         (stop),
        .door_open    (door_open),
        .dir_up       (dir_up),
        .state_dbg    (state_dbg)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [2:0] fexp;
        req   = '0;
        estop = 1'b0;
        rst_n = 1'b1;

        // Reset asserted between edges
        #1 rst_n = 1'b0;
        #1;
        check("rst_floor", 32'(floor), 32'd0);
        check("rst_stop", 32'(stop), 32'd1);
        check("rst_up", 32'(up), 32'd0);
        check("rst_down", 32'(down), 32'd0);
        check("rst_door", 32'(door_open), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_dir_up", 32'(dir_up), 32'd1);
        check("rst_onehot", 32'(floor_onehot), 32'h01);
        step(2);
        rst_n = 1'b1;

        // Single call from floor 0 to floor 3
        req = 5'b01000;
        step(1);
        req = '0;
        check("t2_pending", 32'(pending), 32'h08);
        check("t2_up_e0", 32'(up), 32'd0);
        for (int i = 1; i <= 13; i++) begin
            step(1);
            fexp = (i >= 13) ? 3'd3 : (i >= 9) ? 3'd2 : (i >= 5) ? 3'd1 : 3'd0;
            check("t2_up", 32'(up), 32'(i < 13));
            check("t2_floor", 32'(floor), 32'(fexp));
        end
        check("t2_door_e13", 32'(door_open), 32'd1);
        check("t2_pend_clr", 32'(pending), 32'd0);
        check("t2_onehot", 32'(floor_onehot), 32'h08);
        for (int i = 14; i <= 15; i++) begin
            step(1);
            check("t2_door", 32'(door_open), 32'd1);
        end
        step(1);
        check("t2_door_closed", 32'(door_open), 32'd0);
        check("t2_stop_idle", 32'(stop), 32'd1);
        check("t2_state_idle", 32'(state_dbg), 32'd0);

        // Move down to floor 2 and let the door cycle finish
        req = 5'b00100;
        step(1);
        req = '0;
        step(1);
        check("t3_pre_down", 32'(down), 32'd1);
        check("t3_pre_dir", 32'(dir_up), 32'd0);
        step(4);
        check("t3_pre_floor", 32'(floor), 32'd2);
        check("t3_pre_door", 32'(door_open), 32'd1);
        step(3);
        check("t3_pre_closed", 32'(door_open), 32'd0);

        // Call at current floor, then reopen during dwell
        req = 5'b00100;
        step(1);
        req = '0;
        check("t3_door_e0", 32'(door_open), 32'd0);
        check("t3_pend_e0", 32'(pending), 32'h04);
        step(1);
        check("t3_door_e1", 32'(door_open), 32'd1);
        check("t3_pend_e1", 32'(pending), 32'd0);
        step(1);
        req = 5'b00100;
        step(1);
        req = '0;
        check("t3_door_e3", 32'(door_open), 32'd1);
        check("t3_pend_e3", 32'(pending), 32'd0);
        step(1);
        check("t3_door_e4", 32'(door_open), 32'd1);
        step(1);
        check("t3_door_e5", 32'(door_open), 32'd1);
        step(1);
        check("t3_door_e6", 32'(door_open), 32'd0);
        check("t3_stop_e6", 32'(stop), 32'd1);

        // Reposition to floor 1
        req = 5'b00010;
        step(1);
        req = '0;
        step(8);
        check("t4_pre_floor", 32'(floor), 32'd1);
        check("t4_pre_door", 32'(door_open), 32'd0);

        // SCAN: up to 4 with 3 and 0 injected after departure
        req = 5'b10000;
        step(1);
        req = '0;
        step(1);
        check("t4_up_e1", 32'(up), 32'd1);
        check("t4_dir_e1", 32'(dir_up), 32'd1);
        req = 5'b01001;
        step(1);
        req = '0;
        check("t4_pend_e2", 32'(pending), 32'h19);
        step(7);
        check("t4_floor_e9", 32'(floor), 32'd3);
        check("t4_door_e9", 32'(door_open), 32'd1);
        check("t4_pend_e9", 32'(pending), 32'h11);
        step(3);
        check("t4_door_e12", 32'(door_open), 32'd0);
        check("t4_stop_e12", 32'(stop), 32'd1);
        step(1);
        check("t4_up_e13", 32'(up), 32'd1);
        check("t4_dir_e13", 32'(dir_up), 32'd1);
        step(4);
        check("t4_floor_e17", 32'(floor), 32'd4);
        check("t4_door_e17", 32'(door_open), 32'd1);
        check("t4_pend_e17", 32'(pending), 32'h01);
        step(4);
        check("t4_down_e21", 32'(down), 32'd1);
        check("t4_dir_e21", 32'(dir_up), 32'd0);
        step(12);
        check("t4_floor_e33", 32'(floor), 32'd1);
        check("t4_door_e33", 32'(door_open), 32'd0);
        step(4);
        check("t4_floor_e37", 32'(floor), 32'd0);
        check("t4_door_e37", 32'(door_open), 32'd1);
        check("t4_pend_e37", 32'(pending), 32'd0);
        step(3);
        check("t4_stop_e40", 32'(stop), 32'd1);
        check("t4_door_e40", 32'(door_open), 32'd0);

        // Emergency stop mid-floor with travel count frozen at 2
        req = 5'b10000;
        step(1);
        req = '0;
        step(2);
        check("t5_up_e2", 32'(up), 32'd1);
        estop = 1'b1;
        step(1);
        check("t5_up_e3", 32'(up), 32'd0);
        check("t5_stop_e3", 32'(stop), 32'd1);
        req = 5'b00010;
        step(1);
        req = '0;
        check("t5_pend_e4", 32'(pending), 32'h12);
        check("t5_up_e4", 32'(up), 32'd0);
        step(3);
        check("t5_up_e7", 32'(up), 32'd0);
        check("t5_state_e7", 32'(state_dbg), 32'd1);
        estop = 1'b0;
        step(1);
        check("t5_up_e8", 32'(up), 32'd1);
        check("t5_floor_e8", 32'(floor), 32'd0);
        step(1);
        check("t5_floor_e9", 32'(floor), 32'd0);
        check("t5_up_e9", 32'(up), 32'd1);
        step(1);
        check("t5_floor_e10", 32'(floor), 32'd1);
        check("t5_door_e10", 32'(door_open), 32'd1);
        check("t5_pend_e10", 32'(pending), 32'h10);

        // Travel to floor 4, then reset while moving down
        step(19);
        check("t6_pre_floor", 32'(floor), 32'd4);
        check("t6_pre_door", 32'(door_open), 32'd0);
        req = 5'b00001;
        step(1);
        req = '0;
        step(2);
        check("t6_down_e2", 32'(down), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_floor", 32'(floor), 32'd0);
        check("t6_rst_down", 32'(down), 32'd0);
        check("t6_rst_stop", 32'(stop), 32'd1);
        check("t6_rst_pend", 32'(pending), 32'd0);
        check("t6_rst_dir", 32'(dir_up), 32'd1);
        check("t6_rst_door", 32'(door_open), 32'd0);
        step(1);
        rst_n = 1'b1;
        req = 5'b10000;
        step(1);
        req = '0;
        step(1);
        check("t6_up_after", 32'(up), 32'd1);
        check("t6_floor_after", 32'(floor), 32'd0);
        step(4);
        check("t6_floor_e5", 32'(floor), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
